sha256_rr_arbiter: RTL

- Shares a single sha256_core between NUM_REQ independent requesters.
- Picks one pending 512-bit block by round-robin and issues it to the core with a one-cycle start pulse.
- Waits for the digest, then returns it to the winning requester under a valid/ready handshake.
- Includes a watchdog so a stalled core cannot lock out the other requesters.

---
 rtl/sha256_pkg.sv | 14 +
 rtl/sha256_rr_picker.sv | 31 +++
 rtl/sha256_rr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 sizes, arbiter defaults and arbiter state type
package sha256_pkg;

    localparam int BLOCK_SIZE      = 256;
    localparam int SHA_ARB_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sha256_rr_picker.sv
// rtl/sha256_rr_picker.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module sha256_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any
);

    int idx;

    // Scan from the farthest offset back toward ptr so the closest request is assigned last.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IW'(idx)]) begin
                winner = IW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sha256_rr_arbiter.sv
// rtl/sha256_rr_arbiter.sv - round-robin sharing of one sha256_core between NUM_REQ requesters
module sha256_rr_arbiter
    import sha256_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = SHA_ARB_TIMEOUT,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*2*BLOCK_SIZE-1:0] req_msg_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [BLOCK_SIZE-1:0]         rsp_md_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic                          core_start_o,
    output logic [2*BLOCK_SIZE-1:0]       core_msg_o,
    input  logic [BLOCK_SIZE-1:0]         core_md_i,
    input  logic                          core_valid_i,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [IW-1:0]                 err_id_o
);

    localparam int MW = 2 * BLOCK_SIZE;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt_q;
    logic [IW-1:0]         winner;
    logic                  any_req;
    logic [MW-1:0]         msg_q;
    logic [BLOCK_SIZE-1:0] md_q;
    logic [CW-1:0]         wait_cnt;
    logic                  err_q;
    logic [IW-1:0]         err_id_q;
    logic                  timeout;
    logic [MW-1:0]         slice [NUM_REQ];

    sha256_rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req    (req_valid_i),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            slice[k] = req_msg_i[k*MW +: MW];
        end
    end

    // A late valid on the last allowed cycle still wins over the watchdog.
    assign timeout = (state == WAIT) && !core_valid_i &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (core_valid_i) begin
                    state_nxt = RESP;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    if (rsp_ready_i[gnt_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ptr      <= '0;
            gnt_q    <= '0;
            msg_q    <= '0;
            md_q     <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_q <= timeout;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        msg_q <= slice[winner];
                        gnt_q <= winner;
                        ptr   <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    end
                end
                START: wait_cnt <= '0;
                WAIT: begin
                    if (core_valid_i) begin
                        md_q <= core_md_i;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (timeout) begin
                        err_id_q <= gnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (rstn_i && state == IDLE && any_req) begin
            req_ready_o[winner] = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid_o[gnt_q] = 1'b1;
        end
    end

    assign core_start_o = (state == START);
    assign core_msg_o   = msg_q;
    assign rsp_md_o     = md_q;
    assign busy_o       = (state != IDLE);
    assign err_o        = err_q;
    assign err_id_o     = err_id_q;

endmodule
